ts_packet_scheduler: RTL and testbench

Byte-paced TS output scheduler. At every 188-byte packet boundary it picks one of three sources: the PSI table inserter, the main stream packet FIFO, or an internally generated null packet. It produces the per-packet byte index and TABLE_SENT handshake that drive the table inserter, and the read strobe for the stream FIFO. The block sits between the table inserter / stream FIFO and the T2-MI packer input, so the packer sees a constant-rate TS.

---
 rtl/ts_packet_scheduler_pkg.sv | 9 +
 rtl/ts_packet_scheduler_if.sv | 14 +
 rtl/ts_packet_scheduler_null_gen.sv | 15 +
 rtl/ts_packet_scheduler.sv | 72 +++++++
 tb/tb_ts_packet_scheduler.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ts_packet_scheduler_pkg.sv
// ts_packet_scheduler_pkg: shared TS constants, source/state encoding and null packet header bytes
package ts_packet_scheduler_pkg;
  localparam logic [7:0] TS_SYNC = 8'h47;
  localparam int TS_PKT_LEN = 188;
  localparam logic [12:0] NULL_PID_DEF = 13'h1FFF;
  localparam logic [7:0] NULL_TSC_AFC = 8'h10;
  localparam logic [7:0] NULL_FILL = 8'hFF;
  typedef enum logic [1:0] {S_IDLE, S_TABLE, S_STREAM, S_NULL} src_t;
endpackage

// File: rtl/ts_packet_scheduler_if.sv
// ts_packet_scheduler_if: source handshakes and TS output bus around the scheduler
interface ts_packet_scheduler_if;
  logic BYTE_EN, TABLE_READY, TABLE_SENT, STREAM_PKT_RDY, STREAM_RD, TS_VALID, TS_SOP, SYNC_ERR;
  logic [7:0] TABLE_DATA, PAYLOAD_CNT, STREAM_DATA, TS_DATA;
  logic [15:0] NULL_CNT;
  modport master (
    input BYTE_EN, TABLE_READY, TABLE_DATA, STREAM_PKT_RDY, STREAM_DATA,
    output PAYLOAD_CNT, TABLE_SENT, STREAM_RD, TS_DATA, TS_VALID, TS_SOP, SYNC_ERR, NULL_CNT
  );
  modport slave (
    output BYTE_EN, TABLE_READY, TABLE_DATA, STREAM_PKT_RDY, STREAM_DATA,
    input PAYLOAD_CNT, TABLE_SENT, STREAM_RD, TS_DATA, TS_VALID, TS_SOP, SYNC_ERR, NULL_CNT
  );
endinterface

// File: rtl/ts_packet_scheduler_null_gen.sv
// ts_null_gen: maps a packet byte index to the corresponding null packet byte
module ts_null_gen
  import ts_packet_scheduler_pkg::*;
#(
  parameter logic [12:0] NULL_PID = NULL_PID_DEF
) (
  input  logic [7:0] idx,
  output logic [7:0] data
);
  always_comb
    data = idx == 8'd0 ? TS_SYNC :
           idx == 8'd1 ? {3'b000, NULL_PID[12:8]} :
           idx == 8'd2 ? NULL_PID[7:0] :
           idx == 8'd3 ? NULL_TSC_AFC : NULL_FILL;
endmodule

// File: rtl/ts_packet_scheduler.sv
// ts_packet_scheduler: byte-paced TS scheduler choosing table, stream or null source at each packet boundary
module ts_packet_scheduler
  import ts_packet_scheduler_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN,
  parameter int TABLE_MAX_RUN = 2,
  parameter logic [12:0] NULL_PID = NULL_PID_DEF
) (
  input logic CLK,
  input logic RST,
  ts_packet_scheduler_if.master bus
);
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);
  localparam logic [7:0] RUN_MAX = 8'(TABLE_MAX_RUN);
  src_t state, state_d, cur, dec, p_src;
  logic [7:0] cnt_d, run, run_d, p_idx, null_byte;
  logic p_val;
  ts_null_gen #(.NULL_PID(NULL_PID)) u_null (.idx(p_idx), .data(null_byte));
  always_comb
    dec = bus.TABLE_READY && (run < RUN_MAX || !bus.STREAM_PKT_RDY) ? S_TABLE :
          bus.STREAM_PKT_RDY ? S_STREAM :
          bus.TABLE_READY ? S_TABLE : S_NULL;
  // IDLE doubles as decision-pending: the strobe that leaves it also requests byte 0
  always_comb begin
    cur = state == S_IDLE ? dec : state;
    state_d = state;
    cnt_d = bus.PAYLOAD_CNT;
    run_d = run;
    if (bus.BYTE_EN) begin
      state_d = bus.PAYLOAD_CNT == LAST ? S_IDLE : cur;
      cnt_d = bus.PAYLOAD_CNT == LAST ? 8'd0 : bus.PAYLOAD_CNT + 8'd1;
      if (state == S_IDLE)
        run_d = dec != S_TABLE ? 8'd0 : run >= RUN_MAX ? run : run + 8'd1;
    end
    bus.STREAM_RD = bus.BYTE_EN && cur == S_STREAM;
    bus.TABLE_SENT = bus.BYTE_EN && cur == S_TABLE && bus.PAYLOAD_CNT == LAST;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_IDLE;
      bus.PAYLOAD_CNT <= '0;
      run <= '0;
    end else begin
      state <= state_d;
      bus.PAYLOAD_CNT <= cnt_d;
      run <= run_d;
    end
  // source tag travels with each request so a boundary switch never mixes packets
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      p_val <= 1'b0;
      p_src <= S_IDLE;
      p_idx <= '0;
      bus.TS_DATA <= '0;
      bus.TS_VALID <= 1'b0;
      bus.TS_SOP <= 1'b0;
      bus.SYNC_ERR <= 1'b0;
      bus.NULL_CNT <= '0;
    end else begin
      p_val <= bus.BYTE_EN;
      p_src <= cur;
      p_idx <= bus.PAYLOAD_CNT;
      bus.TS_VALID <= p_val;
      bus.TS_SOP <= p_val && p_idx == 8'd0;
      if (p_val)
        bus.TS_DATA <= p_src == S_TABLE ? bus.TABLE_DATA : p_src == S_STREAM ? bus.STREAM_DATA : null_byte;
      if (p_val && p_idx == 8'd0 && p_src == S_STREAM && bus.STREAM_DATA != TS_SYNC)
        bus.SYNC_ERR <= 1'b1;
      if (p_val && p_idx == 8'd0 && p_src == S_NULL)
        bus.NULL_CNT <= bus.NULL_CNT + 16'd1;
    end
endmodule

// File: tb/tb_ts_packet_scheduler.sv
// tb_ts_packet_scheduler: randomized stimulus checked against a packet-level reference model
module tb_ts_packet_scheduler;
  localparam int SRC_T = 1, SRC_S = 2, SRC_N = 3, LEN = 188, MAX_RUN = 2;
  typedef struct {logic [7:0] d; bit sop; int src; int due;} exp_t;
  logic clk = 0, rst = 0;
  int total = 0, bad = 0, cyc = 0, k = 0, m_src = SRC_N, m_run = 0, m_null = 0, rd_cnt = 0, dut_code = 0;
  bit m_sync = 0;
  logic [7:0] spkt [LEN];
  logic [7:0] nh [4] = '{8'h47, 8'h1F, 8'hFF, 8'h10};
  logic [7:0] sq [$];
  exp_t exp_q [$];
  ts_packet_scheduler_if bus();
  ts_packet_scheduler dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] tbl(input int i);
    return 8'(i * 5 + 33);
  endfunction

  function automatic logic [7:0] exp_byte(input int src, input int i);
    return src == SRC_T ? tbl(i) : src == SRC_S ? spkt[i] : i < 4 ? nh[i] : 8'hFF;
  endfunction

  task automatic push_pkt(input logic [7:0] b0);
    sq.push_back(b0);
    repeat (LEN - 1) sq.push_back(8'($urandom));
  endtask

  task automatic check_out();
    exp_t e;
    if (bus.TS_VALID) begin
      if (exp_q.size() == 0) chk("extra_valid", 32'(bus.TS_VALID), 0);
      else begin
        e = exp_q.pop_front();
        if (e.sop && e.src == SRC_S && e.d != 8'h47) m_sync = 1;
        if (e.sop && e.src == SRC_N) m_null++;
        chk("ts_data", 32'(bus.TS_DATA), 32'(e.d));
        chk("ts_sop", 32'(bus.TS_SOP), 32'(e.sop));
        chk("latency", cyc, e.due);
      end
    end else begin
      chk("sop_idle", 32'(bus.TS_SOP), 0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        chk("ts_valid", 32'(bus.TS_VALID), 1);
        void'(exp_q.pop_front());
      end
    end
    chk("sync_err", 32'(bus.SYNC_ERR), 32'(m_sync));
    chk("null_cnt", 32'(bus.NULL_CNT), 32'(m_null & 16'hFFFF));
  endtask

  task automatic step(input bit en);
    logic [7:0] req_idx;
    bit req_en, req_rd;
    bus.BYTE_EN = en;
    bus.STREAM_PKT_RDY = sq.size() >= LEN;
    if (en && k == 0) begin
      if (bus.TABLE_READY && (m_run < MAX_RUN || !bus.STREAM_PKT_RDY)) m_src = SRC_T;
      else if (bus.STREAM_PKT_RDY) m_src = SRC_S;
      else if (bus.TABLE_READY) m_src = SRC_T;
      else m_src = SRC_N;
      m_run = m_src == SRC_T ? (m_run < MAX_RUN ? m_run + 1 : MAX_RUN) : 0;
      if (m_src == SRC_S) for (int i = 0; i < LEN; i++) spkt[i] = sq[i];
    end
    #1;
    chk("payload_cnt", 32'(bus.PAYLOAD_CNT), k);
    chk("stream_rd", 32'(bus.STREAM_RD), 32'(en && m_src == SRC_S));
    chk("table_sent", 32'(bus.TABLE_SENT), 32'(en && m_src == SRC_T && k == LEN - 1));
    if (en && bus.TABLE_SENT) dut_code = dut_code * 4 + SRC_T;
    if (en && bus.STREAM_RD && bus.PAYLOAD_CNT == 8'(LEN - 1)) dut_code = dut_code * 4 + SRC_S;
    if (bus.STREAM_RD) rd_cnt++;
    if (en) begin
      exp_q.push_back('{d: exp_byte(m_src, k), sop: k == 0, src: m_src, due: cyc + 2});
      k = (k + 1) % LEN;
    end
    req_idx = bus.PAYLOAD_CNT;
    req_en = en;
    req_rd = bus.STREAM_RD;
    @(posedge clk);
    #1;
    cyc++;
    bus.TABLE_DATA = req_en ? tbl(int'(req_idx)) : 8'($urandom);
    bus.STREAM_DATA = req_rd && sq.size() > 0 ? sq.pop_front() : 8'($urandom);
    check_out();
  endtask

  task automatic do_reset();
    bus.BYTE_EN = 0;
    rst = 1;
    #1;
    chk("rst_payload_cnt", 32'(bus.PAYLOAD_CNT), 0);
    chk("rst_ts_valid", 32'(bus.TS_VALID), 0);
    chk("rst_ts_data", 32'(bus.TS_DATA), 0);
    chk("rst_ts_sop", 32'(bus.TS_SOP), 0);
    chk("rst_sync_err", 32'(bus.SYNC_ERR), 0);
    chk("rst_null_cnt", 32'(bus.NULL_CNT), 0);
    chk("rst_stream_rd", 32'(bus.STREAM_RD), 0);
    chk("rst_table_sent", 32'(bus.TABLE_SENT), 0);
    k = 0; m_run = 0; m_null = 0; m_sync = 0;
    exp_q.delete();
    sq.delete();
    @(posedge clk);
    #1;
    rst = 0;
    cyc++;
  endtask

  initial begin
    int ord [6] = '{SRC_T, SRC_T, SRC_S, SRC_T, SRC_T, SRC_S};
    int code = 0;
    bus.BYTE_EN = 0; bus.TABLE_READY = 0; bus.STREAM_PKT_RDY = 0;
    bus.TABLE_DATA = 0; bus.STREAM_DATA = 0;
    #1 do_reset();
    bus.TABLE_READY = 1;
    repeat (LEN) step(1);
    bus.TABLE_READY = 0;
    repeat (3 * LEN) step(1);
    repeat (3) step(0);
    chk("null_cnt_3", 32'(bus.NULL_CNT), 3);
    push_pkt(8'h47);
    push_pkt(8'h47);
    bus.TABLE_READY = 1;
    dut_code = 0;
    rd_cnt = 0;
    repeat (6 * LEN) step(1);
    foreach (ord[i]) code = code * 4 + ord[i];
    chk("order_ttsTTS", dut_code, code);
    chk("stream_rd_total", rd_cnt, 2 * LEN);
    bus.TABLE_READY = 0;
    push_pkt(8'h46);
    repeat (2 * LEN) step(1);
    repeat (3) step(0);
    chk("sync_err_sticky", 32'(bus.SYNC_ERR), 1);
    push_pkt(8'h47);
    dut_code = 0;
    for (int i = 0; i < 2 * LEN; i++) begin
      if (k == 100 && m_src == SRC_S) bus.TABLE_READY = 1;
      step(1);
      repeat (3) step(0);
    end
    chk("order_st", dut_code, SRC_S * 4 + SRC_T);
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < LEN; i++) begin
        if (i == 0 && $urandom_range(0, 1) == 1 && sq.size() < LEN) push_pkt(8'h47);
        bus.TABLE_READY = 1'($urandom_range(0, 1));
        step(1);
        repeat ($urandom_range(0, 3)) step(0);
      end
    bus.TABLE_READY = 1;
    for (int i = 0; i < 400 && !(k == 50 && m_src == SRC_T); i++) step(1);
    chk("reach_idx50", k, 50);
    do_reset();
    repeat (LEN) step(1);
    repeat (4) step(0);
    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
